// File: rtl/ddr3_axi_traffic_gen_if.sv
// ddr3_axi_traffic_gen_if: AXI-lite aw/w/b/ar/r channels between the traffic master and the DDR3 controller
interface ddr3_axi_traffic_gen_if #(
    parameter int ADDR_W = 26
);
    logic [ADDR_W-1:0] awaddr;
    logic              awvalid;
    logic              awready;
    logic [15:0]       wdata;
    logic              wvalid;
    logic              wready;
    logic              bvalid;
    logic              bready;
    logic              bresp;
    logic [ADDR_W-1:0] araddr;
    logic              arvalid;
    logic              arready;
    logic [15:0]       rdata;
    logic              rvalid;
    logic              rready;
    logic              rresp;

    modport master (
        output awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
    );

    modport slave (
        input  awaddr, awvalid, wdata, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bvalid, bresp, arready, rdata, rvalid, rresp
    );
endinterface

// File: rtl/ddr3_axi_traffic_gen.sv
// ddr3_axi_traffic_gen: writes an LFSR sequence over AXI-lite, reads it back and scores mismatches
module ddr3_axi_traffic_gen #(
    parameter int                ADDR_W    = 26,
    parameter int                NUM_WORDS = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int                ADDR_STEP = 1,
    parameter logic [15:0]       SEED      = 16'hACE1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [15:0]           err_count,
    output logic [ADDR_W-1:0]     first_err_addr,
    ddr3_axi_traffic_gen_if.master axi
);
    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE} state_t;

    // an all-zero seed would lock the LFSR, so it is replaced by 1
    localparam logic [15:0]       SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
    localparam logic [ADDR_W-1:0] STEP     = ADDR_W'(ADDR_STEP);
    localparam logic [15:0]       LAST     = 16'(NUM_WORDS - 1);

    state_t            state;
    logic [15:0]       lfsr;
    logic [15:0]       idx;
    logic [15:0]       lfsr_next;
    logic              last;
    logic              err;
    logic [ADDR_W-1:0] err_addr;

    assign lfsr_next = (lfsr >> 1) ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign last      = idx == LAST;
    assign pass      = done && err_count == 16'h0000;
    assign err       = (state == WR_RESP && axi.bvalid && axi.bresp) ||
                       (state == RD_DATA && axi.rvalid && (axi.rresp || axi.rdata != lfsr));
    assign err_addr  = (state == WR_RESP) ? axi.awaddr : axi.araddr;

    // sequencer: write phase, then read-back phase, one transaction outstanding at a time
    always_ff @(posedge aclk) begin
        if (areset) begin
            state          <= IDLE;
            busy           <= 1'b0;
            done           <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            lfsr           <= SEED_EFF;
            idx            <= '0;
            axi.awaddr     <= '0;
            axi.awvalid    <= 1'b0;
            axi.wdata      <= '0;
            axi.wvalid     <= 1'b0;
            axi.bready     <= 1'b0;
            axi.araddr     <= '0;
            axi.arvalid    <= 1'b0;
            axi.rready     <= 1'b0;
        end else begin
            if (err) begin
                err_count <= (err_count == 16'hFFFF) ? err_count : err_count + 16'd1;
                if (err_count == 16'h0000) first_err_addr <= err_addr;
            end
            case (state)
                IDLE, DONE: if (start) begin
                    state          <= WR_REQ;
                    busy           <= 1'b1;
                    done           <= 1'b0;
                    err_count      <= '0;
                    first_err_addr <= '0;
                    idx            <= '0;
                    lfsr           <= SEED_EFF;
                    axi.awaddr     <= BASE_ADDR;
                    axi.wdata      <= SEED_EFF;
                    axi.awvalid    <= 1'b1;
                    axi.wvalid     <= 1'b1;
                end
                WR_REQ: begin
                    if (axi.awready) axi.awvalid <= 1'b0;
                    if (axi.wready) axi.wvalid <= 1'b0;
                    if ((!axi.awvalid || axi.awready) && (!axi.wvalid || axi.wready)) begin
                        state      <= WR_RESP;
                        axi.bready <= 1'b1;
                    end
                end
                WR_RESP: if (axi.bvalid) begin
                    axi.bready <= 1'b0;
                    if (last) begin
                        state       <= RD_REQ;
                        lfsr        <= SEED_EFF;
                        idx         <= '0;
                        axi.araddr  <= BASE_ADDR;
                        axi.arvalid <= 1'b1;
                    end else begin
                        state       <= WR_REQ;
                        lfsr        <= lfsr_next;
                        idx         <= idx + 16'd1;
                        axi.awaddr  <= axi.awaddr + STEP;
                        axi.wdata   <= lfsr_next;
                        axi.awvalid <= 1'b1;
                        axi.wvalid  <= 1'b1;
                    end
                end
                RD_REQ: if (axi.arready) begin
                    state       <= RD_DATA;
                    axi.arvalid <= 1'b0;
                    axi.rready  <= 1'b1;
                end
                RD_DATA: if (axi.rvalid) begin
                    axi.rready <= 1'b0;
                    lfsr       <= lfsr_next;
                    idx        <= idx + 16'd1;
                    if (last) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state       <= RD_REQ;
                        axi.araddr  <= axi.araddr + STEP;
                        axi.arvalid <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr3_axi_traffic_gen.sv
// tb_ddr3_axi_traffic_gen: memory-slave bench with error injection and a word-level reference model
module tb_ddr3_axi_traffic_gen;
    localparam int             AW    = 26;
    localparam int             N     = 4;
    localparam logic [AW-1:0]  BASE1 = 26'h3FFFFFE;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic sel = 1'b0;
    logic clr = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic start0, start1;
    logic busy0, busy1, done0, done1, pass0, pass1;
    logic [15:0] ec0, ec1;
    logic [AW-1:0] fe0, fe1;

    assign start0 = start && !sel;
    assign start1 = start && sel;

    ddr3_axi_traffic_gen_if #(.ADDR_W(AW)) bus0 ();
    ddr3_axi_traffic_gen_if #(.ADDR_W(AW)) bus1 ();

    ddr3_axi_traffic_gen #(.ADDR_W(AW), .NUM_WORDS(N), .BASE_ADDR('0), .ADDR_STEP(1), .SEED(16'hACE1)) dut0 (
        .aclk(clk), .areset(rst), .start(start0), .busy(busy0), .done(done0), .pass(pass0),
        .err_count(ec0), .first_err_addr(fe0), .axi(bus0.master)
    );

    ddr3_axi_traffic_gen #(.ADDR_W(AW), .NUM_WORDS(N), .BASE_ADDR(BASE1), .ADDR_STEP(1), .SEED(16'hACE1)) dut1 (
        .aclk(clk), .areset(rst), .start(start1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(ec1), .first_err_addr(fe1), .axi(bus1.master)
    );

    logic busy, done, pass;
    logic [15:0] err_count;
    logic [AW-1:0] first_err_addr;
    logic [AW-1:0] awaddr, araddr;
    logic [15:0] wdata, rdata;
    logic awvalid, wvalid, bready, arvalid, rready;
    logic awready, wready, bvalid, bresp, arready, rvalid, rresp;

    assign busy           = sel ? busy1 : busy0;
    assign done           = sel ? done1 : done0;
    assign pass           = sel ? pass1 : pass0;
    assign err_count      = sel ? ec1 : ec0;
    assign first_err_addr = sel ? fe1 : fe0;
    assign awaddr         = sel ? bus1.awaddr : bus0.awaddr;
    assign awvalid        = sel ? bus1.awvalid : bus0.awvalid;
    assign wdata          = sel ? bus1.wdata : bus0.wdata;
    assign wvalid         = sel ? bus1.wvalid : bus0.wvalid;
    assign bready         = sel ? bus1.bready : bus0.bready;
    assign araddr         = sel ? bus1.araddr : bus0.araddr;
    assign arvalid        = sel ? bus1.arvalid : bus0.arvalid;
    assign rready         = sel ? bus1.rready : bus0.rready;

    assign bus0.awready = awready && !sel;
    assign bus1.awready = awready && sel;
    assign bus0.wready  = wready && !sel;
    assign bus1.wready  = wready && sel;
    assign bus0.bvalid  = bvalid && !sel;
    assign bus1.bvalid  = bvalid && sel;
    assign bus0.arready = arready && !sel;
    assign bus1.arready = arready && sel;
    assign bus0.rvalid  = rvalid && !sel;
    assign bus1.rvalid  = rvalid && sel;
    assign bus0.bresp   = bresp;
    assign bus1.bresp   = bresp;
    assign bus0.rresp   = rresp;
    assign bus1.rresp   = rresp;
    assign bus0.rdata   = rdata;
    assign bus1.rdata   = rdata;

    int            aw_stall = 0;
    logic          rnd_mode = 1'b0;
    logic [N-1:0]  bmask = '0, rmask = '0, cmask = '0;
    int            aw_cnt, wn, rn, arn, awv_cyc, wv_cyc, aw_unstable;
    logic          rnd_aw, rnd_w, rnd_ar, rnd_b, rnd_r;
    logic          ga, gw, pend_r, p_wait;
    logic [AW-1:0] la, lra, p_addr;
    logic [15:0]   ld;
    logic [15:0]   mem [16];
    logic [AW-1:0] wq_a[$];
    logic [15:0]   wq_d[$];
    logic [AW-1:0] rq_a[$];
    logic          aw_hs, w_hs, ar_hs, commit_w, commit_r;
    logic [AW-1:0] wa_eff, ra_eff;
    logic [15:0]   wd_eff;

    assign awready  = aw_cnt >= aw_stall && rnd_aw;
    assign wready   = rnd_w;
    assign arready  = rnd_ar;
    assign aw_hs    = awvalid && awready;
    assign w_hs     = wvalid && wready;
    assign ar_hs    = arvalid && arready;
    assign commit_w = (ga || aw_hs) && (gw || w_hs) && !bvalid && rnd_b;
    assign commit_r = (pend_r || ar_hs) && !rvalid && rnd_r;
    assign wa_eff   = aw_hs ? awaddr : la;
    assign wd_eff   = w_hs ? wdata : ld;
    assign ra_eff   = ar_hs ? araddr : lra;

    // memory slave: accepts aw/w in any order, responds with optional injected errors, logs traffic
    always @(posedge clk) begin
        rnd_aw <= !rnd_mode || 1'($urandom_range(1));
        rnd_w  <= !rnd_mode || 1'($urandom_range(1));
        rnd_ar <= !rnd_mode || 1'($urandom_range(1));
        rnd_b  <= !rnd_mode || 1'($urandom_range(1));
        rnd_r  <= !rnd_mode || 1'($urandom_range(1));
        if (rst) begin
            ga <= 1'b0; gw <= 1'b0; pend_r <= 1'b0; bvalid <= 1'b0; rvalid <= 1'b0;
            aw_cnt <= 0; bresp <= 1'b0; rresp <= 1'b0; rdata <= '0;
        end else begin
            aw_cnt <= (!awvalid || awready) ? 0 : aw_cnt + 1;
            if (aw_hs) begin ga <= 1'b1; la <= awaddr; end
            if (w_hs) begin gw <= 1'b1; ld <= wdata; end
            if (ar_hs) begin pend_r <= 1'b1; lra <= araddr; end
            if (bvalid && bready) bvalid <= 1'b0;
            if (rvalid && rready) rvalid <= 1'b0;
            if (commit_w) begin
                ga <= 1'b0; gw <= 1'b0; bvalid <= 1'b1;
                bresp <= (wn < N) ? bmask[wn[1:0]] : 1'b0;
                mem[wa_eff[3:0]] <= wd_eff;
                wq_a.push_back(wa_eff);
                wq_d.push_back(wd_eff);
                wn <= wn + 1;
            end
            if (commit_r) begin
                pend_r <= 1'b0; rvalid <= 1'b1;
                rresp <= (rn < N) ? rmask[rn[1:0]] : 1'b0;
                rdata <= (rn < N && cmask[rn[1:0]]) ? 16'h0000 : mem[ra_eff[3:0]];
                rq_a.push_back(ra_eff);
                rn <= rn + 1;
            end
        end
        if (clr) begin
            wn <= 0; rn <= 0; arn <= 0; awv_cyc <= 0; wv_cyc <= 0; aw_unstable <= 0;
            wq_a.delete(); wq_d.delete(); rq_a.delete();
        end else begin
            if (ar_hs) arn <= arn + 1;
            awv_cyc <= awv_cyc + int'(awvalid && !awready);
            wv_cyc  <= wv_cyc + int'(wvalid);
            if (p_wait && (!awvalid || awaddr != p_addr)) aw_unstable <= aw_unstable + 1;
        end
        p_wait <= awvalid && !awready;
        p_addr <= awaddr;
    end

    // reference model: word k holds the k-th LFSR state from the seed at base + k
    function automatic logic [15:0] m_data(int k);
        logic [15:0] l;
        l = 16'hACE1;
        for (int i = 0; i < k; i++) l = l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
        return l;
    endfunction

    function automatic logic [AW-1:0] m_addr(int k);
        return (sel ? BASE1 : '0) + AW'(k);
    endfunction

    // errors are counted write phase first, then read phase, in word order
    task automatic m_expect(output int ec, output logic [AW-1:0] fa);
        ec = 0;
        fa = '0;
        for (int k = 0; k < N; k++)
            if (bmask[k]) begin
                if (ec == 0) fa = m_addr(k);
                ec++;
            end
        for (int k = 0; k < N; k++)
            if (rmask[k] || cmask[k]) begin
                if (ec == 0) fa = m_addr(k);
                ec++;
            end
    endtask

    task automatic run_pass(output int cyc);
        @(negedge clk);
        clr = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        start = 1'b0;
        cyc = 1;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL pass_timeout: done=%0b after %0d cycles, required 1", done, cyc);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({busy, done, pass} !== 3'b000) begin
            errors++;
            $display("FAIL reset_status: busy/done/pass=%b required 000", {busy, done, pass});
        end
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin
            errors++;
            $display("FAIL reset_valids: %b required 00000", {awvalid, wvalid, bready, arvalid, rready});
        end
        checks++;
        if (err_count !== 16'h0 || first_err_addr !== '0) begin
            errors++;
            $display("FAIL reset_err: err_count=%0h first=%0h required 0 0", err_count, first_err_addr);
        end
        checks++;
        if (awaddr !== '0 || araddr !== '0 || wdata !== '0) begin
            errors++;
            $display("FAIL reset_bus: aw=%0h ar=%0h wd=%0h required 0", awaddr, araddr, wdata);
        end
    endtask

    task automatic test_ideal();
        int cyc;
        logic [15:0] lit [N];
        lit = '{16'hACE1, 16'hE270, 16'h7138, 16'h389C};
        bmask = '0; rmask = '0; cmask = '0; aw_stall = 0; rnd_mode = 1'b0;
        run_pass(cyc);
        checks++;
        if (cyc != 4 * N + 1) begin
            errors++;
            $display("FAIL ideal_latency: %0d cycles required %0d", cyc, 4 * N + 1);
        end
        checks++;
        if (wq_a.size() != N || rq_a.size() != N) begin
            errors++;
            $display("FAIL ideal_counts: writes=%0d reads=%0d required %0d", wq_a.size(), rq_a.size(), N);
        end else
            for (int k = 0; k < N; k++) begin
                checks++;
                if (wq_a[k] !== m_addr(k) || wq_d[k] !== lit[k] || rq_a[k] !== m_addr(k)) begin
                    errors++;
                    $display("FAIL ideal_word%0d: wa=%0h wd=%0h ra=%0h required %0h %0h", k, wq_a[k], wq_d[k], rq_a[k], m_addr(k), lit[k]);
                end
            end
        checks++;
        if (pass !== 1'b1 || err_count !== 16'h0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL ideal_result: pass=%b err=%0h busy=%b required 1 0 0", pass, err_count, busy);
        end
    endtask

    task automatic test_corrupt();
        int cyc, ec;
        logic [AW-1:0] fa;
        bmask = '0; rmask = '0; cmask = 4'b0100;
        m_expect(ec, fa);
        run_pass(cyc);
        checks++;
        if (err_count !== 16'(ec) || first_err_addr !== fa || pass !== 1'b0) begin
            errors++;
            $display("FAIL corrupt: err=%0h first=%0h pass=%b required %0h %0h 0", err_count, first_err_addr, pass, ec, fa);
        end
        cmask = '0;
    endtask

    task automatic test_aw_stall();
        int cyc;
        aw_stall = 3;
        run_pass(cyc);
        checks++;
        if (awv_cyc != 3 * N || wv_cyc != N) begin
            errors++;
            $display("FAIL aw_stall_cycles: aw_wait=%0d w_cycles=%0d required %0d %0d", awv_cyc, wv_cyc, 3 * N, N);
        end
        checks++;
        if (aw_unstable != 0) begin
            errors++;
            $display("FAIL aw_stall_stable: %0d unstable cycles required 0", aw_unstable);
        end
        checks++;
        if (wq_a.size() != N || pass !== 1'b1) begin
            errors++;
            $display("FAIL aw_stall_result: writes=%0d pass=%b required %0d 1", wq_a.size(), pass, N);
        end
        aw_stall = 0;
    endtask

    task automatic test_resp_err();
        int cyc, ec;
        logic [AW-1:0] fa;
        bmask = 4'b0010; rmask = 4'b1000; cmask = '0;
        m_expect(ec, fa);
        run_pass(cyc);
        checks++;
        if (err_count !== 16'(ec) || first_err_addr !== fa || pass !== 1'b0) begin
            errors++;
            $display("FAIL resp_err: err=%0h first=%0h pass=%b required %0h %0h 0", err_count, first_err_addr, pass, ec, fa);
        end
        checks++;
        if (rq_a.size() != N) begin
            errors++;
            $display("FAIL resp_err_reads: %0d reads required %0d", rq_a.size(), N);
        end
        bmask = '0; rmask = '0;
    endtask

    task automatic test_reset_mid();
        int n, cyc;
        bmask = 4'b0001;
        @(negedge clk);
        clr = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        start = 1'b0;
        n = 0;
        while (!(rready && arn == 3) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!(rready && arn == 3) || err_count !== 16'd1) begin
            errors++;
            $display("FAIL reset_mid_reach: rready=%b ar=%0d err=%0h required 1 3 1", rready, arn, err_count);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({awvalid, wvalid, bready, arvalid, rready, busy, done} !== 7'b0 || err_count !== 16'h0) begin
            errors++;
            $display("FAIL reset_mid_state: %b err=%0h required 0000000 0",
                     {awvalid, wvalid, bready, arvalid, rready, busy, done}, err_count);
        end
        bmask = '0;
        run_pass(cyc);
        checks++;
        if (pass !== 1'b1 || cyc != 4 * N + 1 || wq_a.size() != N) begin
            errors++;
            $display("FAIL reset_mid_rerun: pass=%b cycles=%0d writes=%0d required 1 %0d %0d", pass, cyc, wq_a.size(), 4 * N + 1, N);
        end
    endtask

    task automatic test_wrap();
        int cyc;
        sel = 1'b1;
        run_pass(cyc);
        checks++;
        if (wq_a.size() != N) begin
            errors++;
            $display("FAIL wrap_count: %0d writes required %0d", wq_a.size(), N);
        end else
            for (int k = 0; k < N; k++) begin
                checks++;
                if (wq_a[k] !== m_addr(k) || wq_d[k] !== m_data(k)) begin
                    errors++;
                    $display("FAIL wrap_word%0d: addr=%0h data=%0h required %0h %0h", k, wq_a[k], wq_d[k], m_addr(k), m_data(k));
                end
            end
        checks++;
        if (wq_a.size() == N && (wq_a[1] !== 26'h3FFFFFF || wq_a[2] !== 26'h0)) begin
            errors++;
            $display("FAIL wrap_edge: addr1=%0h addr2=%0h required 3ffffff 0", wq_a[1], wq_a[2]);
        end
        checks++;
        if (pass !== 1'b1) begin
            errors++;
            $display("FAIL wrap_pass: pass=%b required 1", pass);
        end
        sel = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cyc, ec;
        logic [AW-1:0] fa;
        @(negedge clk);
        clr = 1'b1;
        start = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        start = 1'b0;
        cyc = 1;
        repeat (4) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_busy: busy=%b done=%b required 1 0", busy, done);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc++;
        while (!done && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (cyc != 4 * N + 1 || wq_a.size() != N || pass !== 1'b1) begin
            errors++;
            $display("FAIL b2b_ignore_start: cycles=%0d writes=%0d pass=%b required %0d %0d 1", cyc, wq_a.size(), pass, 4 * N + 1, N);
        end
        cmask = 4'b1000;
        m_expect(ec, fa);
        run_pass(cyc);
        checks++;
        if (err_count !== 16'(ec) || first_err_addr !== fa || cyc != 4 * N + 1) begin
            errors++;
            $display("FAIL b2b_restart: err=%0h first=%0h cycles=%0d required %0h %0h %0d", err_count, first_err_addr, cyc, ec, fa, 4 * N + 1);
        end
        cmask = '0;
    endtask

    task automatic test_random();
        int cyc, ec;
        logic [AW-1:0] fa;
        rnd_mode = 1'b1;
        for (int it = 0; it < 8; it++) begin
            sel   = 1'($urandom_range(1));
            bmask = 4'($urandom);
            rmask = 4'($urandom) & 4'($urandom);
            cmask = 4'($urandom) & 4'($urandom);
            m_expect(ec, fa);
            run_pass(cyc);
            checks++;
            if (err_count !== 16'(ec) || first_err_addr !== fa || pass !== (ec == 0)) begin
                errors++;
                $display("FAIL random%0d: err=%0h first=%0h pass=%b required %0h %0h %b", it, err_count, first_err_addr, pass, ec, fa, ec == 0);
            end
            checks++;
            if (wq_a.size() != N || rq_a.size() != N) begin
                errors++;
                $display("FAIL random%0d_counts: writes=%0d reads=%0d required %0d", it, wq_a.size(), rq_a.size(), N);
            end else
                for (int k = 0; k < N; k++) begin
                    checks++;
                    if (wq_a[k] !== m_addr(k) || wq_d[k] !== m_data(k) || rq_a[k] !== m_addr(k)) begin
                        errors++;
                        $display("FAIL random%0d_word%0d: wa=%0h wd=%0h ra=%0h required %0h %0h", it, k, wq_a[k], wq_d[k], rq_a[k], m_addr(k), m_data(k));
                    end
                end
        end
        rnd_mode = 1'b0;
        sel = 1'b0;
        bmask = '0; rmask = '0; cmask = '0;
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_corrupt();
        test_aw_stall();
        test_resp_err();
        test_reset_mid();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
